// File: rtl/hdr_weight_pipe.sv
// hdr_weight_pipe: per-exposure triangle weights for an HDR merge, two-stage elastic pipeline.
// Optional lane clipping is compiled in when HDR_W_CLIP_EN is defined.
module hdr_weight_pipe #(
    parameter int N         = 8,
    parameter int K         = 3,
    parameter int FRAME_PIX = 307200,
    parameter int CLIP_LO   = 4,
    parameter int CLIP_HI   = (1 << N) - 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [K*N-1:0]         in_pix,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [K*N-1:0]         out_w,
    output logic [N+$clog2(K)-1:0] out_wsum,
    output logic                   out_last,
    output logic                   out_zero,
    output logic                   len_err
);
    localparam int           SW        = N + $clog2(K);
    localparam logic [23:0]  LAST_IDX  = 24'(FRAME_PIX - 1);
    localparam logic [N-1:0] ONE_N     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] CLIP_LO_P = N'(CLIP_LO);
    localparam logic [N-1:0] CLIP_HI_P = N'(CLIP_HI);
`ifdef HDR_W_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    logic           adv;
    logic           accept;
    logic [K*N-1:0] w_next;
    logic [SW-1:0]  wsum_next;

    logic           s1_valid_reg;
    logic [K*N-1:0] s1_w_reg;
    logic           s1_last_reg;

    logic           s2_valid_reg;
    logic [K*N-1:0] s2_w_reg;
    logic [SW-1:0]  s2_wsum_reg;
    logic           s2_last_reg;

    logic [23:0]    pcnt_reg;
    logic           len_err_reg;

    // Both stages move together; a full S2 that is not being drained freezes the whole pipe.
    assign adv      = out_ready || !s2_valid_reg;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_lane
            logic [N-1:0] p;
            logic [N-1:0] tri_w;
            logic         clip;
            assign p     = in_pix[gi*N +: N];
            // 2^N - p reduced modulo 2^N is simply -p; the result never exceeds 2^(N-1).
            assign tri_w = p[N-1] ? ({N{1'b0}} - p) : (p + ONE_N);
            assign clip  = CLIP_ON && ((p <= CLIP_LO_P) || (p >= CLIP_HI_P));
            assign w_next[gi*N +: N] = clip ? {N{1'b0}} : tri_w;
        end
    endgenerate

    always_comb begin
        wsum_next = '0;
        for (int e = 0; e < K; e++) begin
            wsum_next = wsum_next + SW'(s1_w_reg[e*N +: N]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_w_reg     <= '0;
            s1_last_reg  <= 1'b0;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            s1_w_reg     <= w_next;
            s1_last_reg  <= in_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_w_reg     <= '0;
            s2_wsum_reg  <= '0;
            s2_last_reg  <= 1'b0;
        end else if (adv) begin
            s2_valid_reg <= s1_valid_reg;
            s2_w_reg     <= s1_w_reg;
            s2_wsum_reg  <= wsum_next;
            s2_last_reg  <= s1_last_reg;
        end
    end

`ifdef HDR_W_CLIP_EN
    // Unclipped weights are at least 1, so a zero sum means every lane was clipped.
    logic s2_zero_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_zero_reg <= 1'b0;
        end else if (adv) begin
            s2_zero_reg <= (wsum_next == '0);
        end
    end
    assign out_zero = s2_zero_reg;
`else
    assign out_zero = 1'b0;
`endif

    // Frame length tracking: a frame ends at in_last or by overrunning FRAME_PIX beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_reg    <= '0;
            len_err_reg <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                pcnt_reg <= '0;
                if (pcnt_reg != LAST_IDX) begin
                    len_err_reg <= 1'b1;
                end
            end else if (pcnt_reg == LAST_IDX) begin
                pcnt_reg    <= '0;
                len_err_reg <= 1'b1;
            end else begin
                pcnt_reg <= pcnt_reg + 24'd1;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_w     = s2_w_reg;
    assign out_wsum  = s2_wsum_reg;
    assign out_last  = s2_last_reg;
    assign len_err   = len_err_reg;

endmodule

// File: tb/tb_hdr_weight_pipe.sv
// Directed bench for hdr_weight_pipe: main instance N=8 K=3 FRAME_PIX=4, second instance K=4.
// Clip expectations switch on HDR_W_CLIP_EN.
module tb_hdr_weight_pipe;
    localparam int N   = 8;
    localparam int K   = 3;
    localparam int SW  = 10;
    localparam int K4  = 4;
    localparam int SW4 = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [K*N-1:0]    in_pix = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [K*N-1:0]    out_w;
    logic [SW-1:0]     out_wsum;
    logic              out_last;
    logic              out_zero;
    logic              len_err;

    logic              in_valid4 = 1'b0;
    logic              in_ready4;
    logic [K4*N-1:0]   in_pix4 = '0;
    logic              in_last4 = 1'b0;
    logic              out_valid4;
    logic              out_ready4 = 1'b1;
    logic [K4*N-1:0]   out_w4;
    logic [SW4-1:0]    out_wsum4;
    logic              out_last4;
    logic              out_zero4;
    logic              len_err4;

    int total = 0;
    int bad   = 0;

    int             obs_n;
    logic [K*N-1:0] obs_w [0:31];
    logic [SW-1:0]  obs_sum [0:31];
    logic           obs_last [0:31];
    int             held_bad;
    int             ready_bad;
    int             stall_cyc;

    hdr_weight_pipe #(.N(N), .K(K), .FRAME_PIX(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w),
        .out_wsum(out_wsum), .out_last(out_last), .out_zero(out_zero), .len_err(len_err)
    );

    hdr_weight_pipe #(.N(N), .K(K4), .FRAME_PIX(16)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_pix(in_pix4),
        .in_last(in_last4), .out_valid(out_valid4), .out_ready(out_ready4), .out_w(out_w4),
        .out_wsum(out_wsum4), .out_last(out_last4), .out_zero(out_zero4), .len_err(len_err4)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pack3(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
        return {l2, l1, l0};
    endfunction

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    // Streams n beats (lane e of beat j = j + 10e + 20), optionally stalling the sink, and records outputs.
    task automatic run_stream(input int n, input int last_every, input int stall_at, input int stall_len);
        int src;
        int cyc;
        logic [K*N-1:0] pw;
        logic [SW-1:0]  ps;
        logic           pl;
        logic           pv_stall;
        src = 0; cyc = 0; pv_stall = 1'b0; pw = '0; ps = '0; pl = 1'b0;
        obs_n = 0; held_bad = 0; ready_bad = 0; stall_cyc = 0;
        while ((obs_n < n) && (cyc < 60)) begin
            in_valid = (src < n);
            for (int e = 0; e < K; e++) in_pix[e*N +: N] = 8'(src + 10*e + 20);
            in_last   = (last_every != 0) && ((src % last_every) == last_every - 1) && (src < n);
            out_ready = !((cyc >= stall_at) && (cyc < stall_at + stall_len));
            #1;
            if (pv_stall && (!out_valid || out_w !== pw || out_wsum !== ps || out_last !== pl)) held_bad++;
            if (!out_ready && out_valid) begin
                stall_cyc++;
                if (in_ready !== 1'b0) ready_bad++;
            end
            pv_stall = out_valid && !out_ready;
            pw = out_w; ps = out_wsum; pl = out_last;
            if (out_valid && out_ready && obs_n < 32) begin
                obs_w[obs_n] = out_w; obs_sum[obs_n] = out_wsum; obs_last[obs_n] = out_last;
                $display("beat %0d out: w=%h sum=%0d last=%b", obs_n, out_w, out_wsum, out_last);
                obs_n++;
            end
            if (in_valid && in_ready) src++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_pix   = pack3(8'd10, 8'd20, 8'd30);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_w !== '0) begin bad++; $display("FAIL reset_out_w: got %h want 0", out_w); end
        total++; if (out_wsum !== '0) begin bad++; $display("FAIL reset_out_wsum: got %0d want 0", out_wsum); end
        total++; if ({out_last, out_zero, len_err} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {out_last, out_zero, len_err}); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        $display("reset checked: out_valid=%b in_ready=%b", out_valid, in_ready);
    endtask

    task automatic test_triangle();
        logic [23:0] vin [0:3];
        logic [23:0] wexp [0:3];
        logic [9:0]  sexp [0:3];
        vin[0] = pack3(8'd0,   8'd127, 8'd128);
        vin[1] = pack3(8'd255, 8'd64,  8'd200);
        vin[2] = pack3(8'd129, 8'd1,   8'd254);
        vin[3] = pack3(8'd126, 8'd130, 8'd127);
`ifdef HDR_W_CLIP_EN
        wexp[0] = pack3(8'd0,   8'd128, 8'd128); sexp[0] = 10'd256;
        wexp[1] = pack3(8'd0,   8'd65,  8'd56);  sexp[1] = 10'd121;
        wexp[2] = pack3(8'd127, 8'd0,   8'd0);   sexp[2] = 10'd127;
`else
        wexp[0] = pack3(8'd1,   8'd128, 8'd128); sexp[0] = 10'd257;
        wexp[1] = pack3(8'd1,   8'd65,  8'd56);  sexp[1] = 10'd122;
        wexp[2] = pack3(8'd127, 8'd2,   8'd2);   sexp[2] = 10'd131;
`endif
        wexp[3] = pack3(8'd127, 8'd126, 8'd128); sexp[3] = 10'd381;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_pix = vin[i]; in_last = 1'b0; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL tri_early_%0d: out_valid got %b want 0", i, out_valid); end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL tri_latency_%0d: out_valid got %b want 1", i, out_valid); end
            total++; if (out_w !== wexp[i]) begin bad++; $display("FAIL tri_w_%0d: got %h want %h", i, out_w, wexp[i]); end
            total++; if (out_wsum !== sexp[i]) begin bad++; $display("FAIL tri_sum_%0d: got %0d want %0d", i, out_wsum, sexp[i]); end
            $display("tri vec %0d: in=%h w=%h sum=%0d", i, vin[i], out_w, out_wsum);
        end
    endtask

    task automatic test_back_to_back();
        logic [K*N-1:0] we;
        apply_reset();
        run_stream(10, 0, 3, 4);
        total++; if (obs_n !== 10) begin bad++; $display("FAIL stream_count: got %0d want 10", obs_n); end
        total++; if (stall_cyc !== 4) begin bad++; $display("FAIL stream_stall_cycles: got %0d want 4", stall_cyc); end
        total++; if (held_bad !== 0) begin bad++; $display("FAIL stream_hold: %0d cycles changed, want 0", held_bad); end
        total++; if (ready_bad !== 0) begin bad++; $display("FAIL stream_in_ready: %0d stall cycles with in_ready=1, want 0", ready_bad); end
        for (int j = 0; j < obs_n && j < 10; j++) begin
            for (int e = 0; e < K; e++) we[e*N +: N] = 8'(j + 10*e + 21);
            total++; if (obs_w[j] !== we) begin bad++; $display("FAIL stream_w_%0d: got %h want %h", j, obs_w[j], we); end
            total++; if (obs_sum[j] !== 10'(3*j + 93)) begin bad++; $display("FAIL stream_sum_%0d: got %0d want %0d", j, obs_sum[j], 3*j + 93); end
        end
    endtask

    task automatic test_frame_len();
        apply_reset();
        run_stream(4, 4, 99, 0);
        total++; if (obs_n !== 4) begin bad++; $display("FAIL frame_count: got %0d want 4", obs_n); end
        total++; if ({obs_last[3], obs_last[2], obs_last[1], obs_last[0]} !== 4'b1000) begin
            bad++; $display("FAIL frame_last: got %b want 1000", {obs_last[3], obs_last[2], obs_last[1], obs_last[0]});
        end
        total++; if (len_err !== 1'b0) begin bad++; $display("FAIL frame_ok_len_err: got %b want 0", len_err); end
        run_stream(3, 3, 99, 0);
        total++; if (len_err !== 1'b1) begin bad++; $display("FAIL frame_short_len_err: got %b want 1", len_err); end
        run_stream(4, 4, 99, 0);
        total++; if (len_err !== 1'b1) begin bad++; $display("FAIL frame_sticky_len_err: got %b want 1", len_err); end
        $display("frame checks: len_err=%b", len_err);
        apply_reset();
        run_stream(3, 0, 99, 0);
        total++; if (len_err !== 1'b0) begin bad++; $display("FAIL frame_partial_len_err: got %b want 0", len_err); end
        run_stream(1, 0, 99, 0);
        total++; if (len_err !== 1'b1) begin bad++; $display("FAIL frame_overrun_len_err: got %b want 1", len_err); end
        $display("overrun check: len_err=%b", len_err);
    endtask

    task automatic test_reset_flight();
        int late;
        apply_reset();
        in_valid = 1'b1; in_pix = pack3(8'd30, 8'd40, 8'd50); in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_pix = pack3(8'd31, 8'd41, 8'd51);
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flight_pre_valid: got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flight_async_valid: got %b want 0", out_valid); end
        total++; if (out_wsum !== '0) begin bad++; $display("FAIL flight_async_wsum: got %0d want 0", out_wsum); end
        @(posedge clk); #1;
        rst = 1'b0;
        late = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (out_valid) late++;
        end
        total++; if (late !== 0) begin bad++; $display("FAIL flight_no_output: got %0d valid cycles want 0", late); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flight_in_ready: got %b want 1", in_ready); end
        run_stream(4, 4, 99, 0);
        total++; if (obs_n !== 4) begin bad++; $display("FAIL flight_frame_count: got %0d want 4", obs_n); end
        total++; if (len_err !== 1'b0) begin bad++; $display("FAIL flight_len_err: got %b want 0", len_err); end
        $display("reset in flight: late=%0d len_err=%b", late, len_err);
    endtask

    task automatic test_clip();
        logic [23:0] vin [0:3];
        logic [23:0] wexp [0:3];
        logic [9:0]  sexp [0:3];
        logic        zexp [0:3];
        vin[0] = pack3(8'd2,   8'd255, 8'd253);
        vin[1] = pack3(8'd2,   8'd100, 8'd253);
        vin[2] = pack3(8'd4,   8'd5,   8'd251);
        vin[3] = pack3(8'd250, 8'd3,   8'd128);
`ifdef HDR_W_CLIP_EN
        wexp[0] = pack3(8'd0, 8'd0,   8'd0);   sexp[0] = 10'd0;   zexp[0] = 1'b1;
        wexp[1] = pack3(8'd0, 8'd101, 8'd0);   sexp[1] = 10'd101; zexp[1] = 1'b0;
        wexp[2] = pack3(8'd0, 8'd6,   8'd0);   sexp[2] = 10'd6;   zexp[2] = 1'b0;
        wexp[3] = pack3(8'd6, 8'd0,   8'd128); sexp[3] = 10'd134; zexp[3] = 1'b0;
`else
        wexp[0] = pack3(8'd3, 8'd1,   8'd3);   sexp[0] = 10'd7;   zexp[0] = 1'b0;
        wexp[1] = pack3(8'd3, 8'd101, 8'd3);   sexp[1] = 10'd107; zexp[1] = 1'b0;
        wexp[2] = pack3(8'd5, 8'd6,   8'd5);   sexp[2] = 10'd16;  zexp[2] = 1'b0;
        wexp[3] = pack3(8'd6, 8'd4,   8'd128); sexp[3] = 10'd138; zexp[3] = 1'b0;
`endif
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_pix = vin[i]; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clip_valid_%0d: got %b want 1", i, out_valid); end
            total++; if (out_w !== wexp[i]) begin bad++; $display("FAIL clip_w_%0d: got %h want %h", i, out_w, wexp[i]); end
            total++; if (out_wsum !== sexp[i]) begin bad++; $display("FAIL clip_sum_%0d: got %0d want %0d", i, out_wsum, sexp[i]); end
            total++; if (out_zero !== zexp[i]) begin bad++; $display("FAIL clip_zero_%0d: got %b want %b", i, out_zero, zexp[i]); end
            $display("clip vec %0d: in=%h w=%h sum=%0d zero=%b", i, vin[i], out_w, out_wsum, out_zero);
        end
    endtask

    task automatic test_max_sum();
        apply_reset();
        in_valid4 = 1'b1; in_pix4 = {4{8'd128}}; out_ready4 = 1'b1;
        @(posedge clk); #1;
        in_pix4 = {8'd128, 8'd127, 8'd0, 8'd255};
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        total++; if (out_valid4 !== 1'b1) begin bad++; $display("FAIL max_valid: got %b want 1", out_valid4); end
        total++; if (out_w4 !== {4{8'd128}}) begin bad++; $display("FAIL max_w: got %h want 80808080", out_w4); end
        total++; if (out_wsum4 !== 10'd512) begin bad++; $display("FAIL max_sum: got %0d want 512", out_wsum4); end
        $display("max sum: w=%h sum=%0d", out_w4, out_wsum4);
        @(posedge clk); #1;
`ifdef HDR_W_CLIP_EN
        total++; if (out_wsum4 !== 10'd256) begin bad++; $display("FAIL k4_mixed_sum: got %0d want 256", out_wsum4); end
`else
        total++; if (out_wsum4 !== 10'd258) begin bad++; $display("FAIL k4_mixed_sum: got %0d want 258", out_wsum4); end
`endif
        $display("k4 mixed: w=%h sum=%0d", out_w4, out_wsum4);
    endtask

    initial begin
        test_reset();
        test_triangle();
        test_back_to_back();
        test_frame_len();
        test_reset_flight();
        test_clip();
        test_max_sum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
